// File: rtl/pwm_pkg.sv
// Shared defaults, duty type and the saturating duty-step helper for the
// multi-channel PWM generator.
package pwm_pkg;

    localparam int DEF_CNT_W       = 8;
    localparam int DEF_PERIOD_INIT = 9;
    localparam int DEF_DUTY_INIT   = 5;

    typedef logic [DEF_CNT_W-1:0] duty_t;

    // Step a duty value up (clamped to min(per+1, max_val)) or down (clamped to 0).
    // Evaluated one bit wider than the operands so per+1 cannot wrap.
    function automatic logic [31:0] sat_step(
        input logic [31:0] val,
        input logic [31:0] step,
        input logic [31:0] per,
        input logic [31:0] max_val,
        input logic        up
    );
        logic [32:0] v33;
        logic [32:0] s33;
        logic [32:0] lim;
        logic [32:0] sum;
        v33 = {1'b0, val};
        s33 = {1'b0, step};
        lim = {1'b0, per} + 33'd1;
        if (lim > {1'b0, max_val}) begin
            lim = {1'b0, max_val};
        end
        sum = v33 + s33;
        if (up) begin
            if (v33 >= lim) begin
                sat_step = val;
            end else if (sum > lim) begin
                sat_step = lim[31:0];
            end else begin
                sat_step = sum[31:0];
            end
        end else begin
            if (v33 < s33) begin
                sat_step = 32'd0;
            end else begin
                sat_step = val - step;
            end
        end
    endfunction

endpackage

// File: rtl/pwm_multi_channel_btn_cond.sv
// Button conditioner: 2-FF synchroniser, optional tick-based debouncer
// (PWM_DEBOUNCE_EN) and rising-edge detection producing a one-cycle event.
module pwm_btn_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic btn_i,
    output logic evt_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_DEBOUNCE_EN
    logic deb1_q;
    logic deb2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb1_q <= 1'b0;
            deb2_q <= 1'b0;
        end else if (tick_i) begin
            deb1_q <= sync2_q;
            deb2_q <= deb1_q;
        end
    end

    assign evt_o = deb1_q & ~deb2_q & tick_i;
`else
    logic prev_q;
    logic unused_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync2_q;
        end
    end

    assign unused_tick = tick_i;
    assign evt_o       = sync2_q & ~prev_q;
`endif

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: shared period counter, double-buffered per-channel duty
// with write/inc/dec update. Define PWM_DEBOUNCE_EN to debounce the buttons.
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PERIOD_INIT = DEF_PERIOD_INIT,
    parameter int DUTY_INIT   = DEF_DUTY_INIT,
    parameter int STEP        = 1,
    parameter int DEB_DIV     = 4,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [CNT_W-1:0]          period,
    input  logic                      wr_en,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [CNT_W-1:0]          wr_duty,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      period_start,
    output logic [CHANNELS*CNT_W-1:0] duty_rb
);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    per_q, per_d;
    logic [CNT_W-1:0]    duty_sh_q  [CHANNELS];
    logic [CNT_W-1:0]    duty_sh_d  [CHANNELS];
    logic [CNT_W-1:0]    duty_act_q [CHANNELS];
    logic [CNT_W-1:0]    duty_act_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                ps_q, ps_d;
    logic [CHANNELS-1:0] inc_evt;
    logic [CHANNELS-1:0] dec_evt;
    logic                tick;
    logic                boundary;
    logic                reload;

`ifdef PWM_DEBOUNCE_EN
    localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    logic [DW-1:0] deb_cnt_q;

    assign tick = (deb_cnt_q == DW'(DEB_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_q <= '0;
        end else if (tick) begin
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
        end
    end
`else
    localparam int unused_deb_div = DEB_DIV;
    assign tick = 1'b0;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_btn
        pwm_btn_cond u_inc (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_i (tick),
            .btn_i  (inc[g]),
            .evt_o  (inc_evt[g])
        );
        pwm_btn_cond u_dec (
            .clk    (clk),
            .rst_n  (rst_n),
            .tick_i (tick),
            .btn_i  (dec[g]),
            .evt_o  (dec_evt[g])
        );
        assign duty_rb[g*CNT_W +: CNT_W] = duty_act_q[g];
    end

    // While disabled, active registers follow shadow/period so re-enable starts cleanly.
    assign boundary = ena & (cnt_q >= per_q);
    assign reload   = boundary | ~ena;

    always_comb begin
        cnt_d = cnt_q;
        if (!ena || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        per_d = reload ? period : per_q;
        ps_d  = ena & (cnt_q == '0);
        for (int i = 0; i < CHANNELS; i++) begin
            duty_act_d[i] = reload ? duty_sh_q[i] : duty_act_q[i];
            pwm_d[i]      = ena & (cnt_q < duty_act_q[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            duty_sh_d[i] = duty_sh_q[i];
            if (wr_en && (32'(wr_ch) == 32'(i))) begin
                duty_sh_d[i] = wr_duty;
            end else if (inc_evt[i] && !dec_evt[i]) begin
                duty_sh_d[i] = CNT_W'(sat_step(32'(duty_sh_q[i]), 32'(STEP), 32'(per_q),
                                               32'({CNT_W{1'b1}}), 1'b1));
            end else if (dec_evt[i] && !inc_evt[i]) begin
                duty_sh_d[i] = CNT_W'(sat_step(32'(duty_sh_q[i]), 32'(STEP), 32'(per_q),
                                               32'({CNT_W{1'b1}}), 1'b0));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            per_q <= CNT_W'(PERIOD_INIT);
            pwm_q <= '0;
            ps_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= CNT_W'(DUTY_INIT);
                duty_act_q[i] <= CNT_W'(DUTY_INIT);
            end
        end else begin
            cnt_q <= cnt_d;
            per_q <= per_d;
            pwm_q <= pwm_d;
            ps_q  <= ps_d;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule
